decoder38_pulse: RTL and testbench

Sequenced 3-to-8 decoder: accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles. After the pulse it holds a programmable idle gap before it accepts the next code. A sticky per-line record shows which lines have fired since the last clear. It is the decode-side counterpart of the team's 8-to-3 priority encoders, and drives one-hot strobes (LED/segment/select lines) from a compact code bus.

---
 rtl/decoder38_pkg.sv | 14 +
 rtl/dec38.sv | 16 +
 rtl/decoder38_pulse.sv | 100 ++++++++++
 tb/tb_decoder38_pulse.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder38_pkg.sv
// decoder38_pulse shared definitions
// FSM states and code/output widths
package decoder38_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/dec38.sv
// dec38: combinational 3-to-8 one-hot decoder
// Output has exactly one bit set for every code
module dec38
    import decoder38_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  onehot
);

    // Set the single line selected by the code
    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/decoder38_pulse.sv
// decoder38_pulse: handshaked code -> timed one-hot pulse
// Pulse, then idle gap, then ready again; sticky seen record
module decoder38_pulse
    import decoder38_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] x,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic              clr,
    output logic [OUT_W-1:0]  y,
    output logic              y_valid,
    output logic              busy,
    output logic [OUT_W-1:0]  seen
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] P_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] G_LOAD = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [OUT_W-1:0]  dec_y;
    logic              accept;

    dec38 u_dec (
        .code   (x),
        .onehot (dec_y)
    );

    assign x_ready = (state == IDLE) && !rst;
    assign accept  = x_valid && x_ready;
    assign busy    = (state != IDLE);

    // Sequence IDLE -> PULSE -> (GAP) -> IDLE, counter reloaded per state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= PULSE;
                        cnt     <= P_LOAD;
                        y       <= dec_y;
                        y_valid <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        y       <= '0;
                        y_valid <= 1'b0;
                        if (GAP_LEN > 0) begin
                            state <= GAP;
                            cnt   <= G_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    y       <= '0;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky record of fired lines; a clear with an accept keeps only the new bit
    always_ff @(posedge clk) begin
        if (rst) begin
            seen <= '0;
        end else if (accept) begin
            seen <= (clr ? '0 : seen) | dec_y;
        end else if (clr) begin
            seen <= '0;
        end
    end

endmodule

// File: tb/tb_decoder38_pulse.sv
// tb_decoder38_pulse: vectors, directed corners and random vs model
// Two instances: GAP_LEN=1 (a) and GAP_LEN=0 (b) on shared inputs
module tb_decoder38_pulse;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] x;
    logic       x_valid;
    logic       clr;

    logic       ready_a, yv_a, busy_a;
    logic [7:0] y_a, seen_a;
    logic       ready_b, yv_b, busy_b;
    logic [7:0] y_b, seen_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decoder38_pulse #(.PULSE_LEN(P), .GAP_LEN(1)) u_dut_a (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(ready_a),
        .clr(clr), .y(y_a), .y_valid(yv_a), .busy(busy_a), .seen(seen_a)
    );

    decoder38_pulse #(.PULSE_LEN(P), .GAP_LEN(0)) u_dut_b (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(ready_b),
        .clr(clr), .y(y_b), .y_valid(yv_b), .busy(busy_b), .seen(seen_b)
    );

    // Reference: one countdown of remaining busy cycles per instance
    int         m_rem [2];
    logic [2:0] m_code[2];
    logic [7:0] m_seen[2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_rem[d]  = 0;
                m_seen[d] = 8'h00;
            end else if (m_rem[d] == 0 && x_valid) begin
                m_rem[d]  = P + gap_of(d);
                m_code[d] = x;
                m_seen[d] = (clr ? 8'h00 : m_seen[d]) | (8'h01 << x);
            end else begin
                if (m_rem[d] > 0) m_rem[d] = m_rem[d] - 1;
                if (clr) m_seen[d] = 8'h00;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input int d, input logic [7:0] y,
                             input logic yv, input logic bz,
                             input logic rd, input logic [7:0] sn);
        logic       e_yv;
        logic [7:0] e_y;
        e_yv = (m_rem[d] > gap_of(d));
        e_y  = e_yv ? (8'h01 << m_code[d]) : 8'h00;
        chk($sformatf("model[%0d].y", d), 32'(y), 32'(e_y));
        chk($sformatf("model[%0d].y_valid", d), 32'(yv), 32'(e_yv));
        chk($sformatf("model[%0d].busy", d), 32'(bz), 32'(m_rem[d] > 0));
        chk($sformatf("model[%0d].x_ready", d), 32'(rd),
            32'(m_rem[d] == 0 && !rst));
        chk($sformatf("model[%0d].seen", d), 32'(sn), 32'(m_seen[d]));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cmp_model(0, y_a, yv_a, busy_a, ready_a, seen_a);
        cmp_model(1, y_b, yv_b, busy_b, ready_b, seen_b);
    endtask

    task automatic idle_both();
        x_valid = 1'b0;
        clr     = 1'b0;
        repeat (P + 2) step();
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] x;
        logic       clr;
        logic [7:0] y;
        logic       yv;
        logic [7:0] seen;
        logic       xr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v,
                                input logic [2:0] cx, input logic c,
                                input logic [7:0] ey, input logic eyv,
                                input logic [7:0] es, input logic exr);
        vec_t t;
        t.rst = r; t.v = v; t.x = cx; t.clr = c;
        t.y = ey; t.yv = eyv; t.seen = es; t.xr = exr;
        return t;
    endfunction

    vec_t tbl[10];

    initial begin
        // reset, single code x=3, then clear (instance a)
        tbl[0] = mk(1'b1, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tbl[1] = mk(1'b1, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tbl[2] = mk(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tbl[3] = mk(1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0);
        tbl[4] = mk(1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0);
        tbl[5] = mk(1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0);
        tbl[6] = mk(1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0);
        tbl[7] = mk(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0);
        tbl[8] = mk(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1);
        tbl[9] = mk(1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1);

        rst = 1'b1; x_valid = 1'b1; x = 3'd3; clr = 1'b0;
        @(negedge clk);
        chk("reset.x_ready_pre", 32'(ready_a), 32'(0));

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; x_valid = tbl[i].v;
            x = tbl[i].x; clr = tbl[i].clr;
            step();
            chk($sformatf("vec%0d.y", i), 32'(y_a), 32'(tbl[i].y));
            chk($sformatf("vec%0d.y_valid", i), 32'(yv_a), 32'(tbl[i].yv));
            chk($sformatf("vec%0d.seen", i), 32'(seen_a), 32'(tbl[i].seen));
            chk($sformatf("vec%0d.x_ready", i), 32'(ready_a), 32'(tbl[i].xr));
        end

        // sweep with x_valid held high
        idle_both();
        clr = 1'b1; step(); clr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            x = 3'(c); x_valid = 1'b1;
            step();
            chk($sformatf("sweep%0d.y", c), 32'(y_a), 32'(8'h01 << c));
            repeat (P + 1) step();
        end
        chk("sweep.seen", 32'(seen_a), 32'(8'hFF));

        // new code presented while busy is ignored
        idle_both();
        x = 3'd2; x_valid = 1'b1;
        step();
        chk("busy.first", 32'(y_a), 32'(8'h04));
        x = 3'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("busy.hold%0d", i), 32'(y_a), 32'(8'h04));
        end
        step();
        chk("busy.gap", 32'(y_a), 32'(8'h00));
        step();
        chk("busy.idle_y", 32'(y_a), 32'(8'h00));
        chk("busy.idle_rdy", 32'(ready_a), 32'(1));
        step();
        chk("busy.next", 32'(y_a), 32'(8'h20));
        x_valid = 1'b0;

        // reset in the middle of a pulse
        idle_both();
        x = 3'd6; x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        step();
        chk("rstmid.pulse", 32'(y_a), 32'(8'h40));
        rst = 1'b1;
        step();
        chk("rstmid.y", 32'(y_a), 32'(8'h00));
        chk("rstmid.busy", 32'(busy_a), 32'(0));
        chk("rstmid.seen", 32'(seen_a), 32'(8'h00));
        rst = 1'b0; x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        chk("rstmid.reaccept", 32'(y_a), 32'(8'h40));
        repeat (P - 1) step();
        chk("rstmid.last", 32'(y_a), 32'(8'h40));
        step();
        chk("rstmid.end", 32'(y_a), 32'(8'h00));

        // clear colliding with accept, both gap settings
        idle_both();
        clr = 1'b1; step(); clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            x = 3'(c); x_valid = 1'b1;
            step();
            x_valid = 1'b0;
            repeat (P + 1) step();
        end
        chk("clr.pre_a", 32'(seen_a), 32'(8'h0F));
        chk("clr.pre_b", 32'(seen_b), 32'(8'h0F));
        x = 3'd7; x_valid = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr.seen_a", 32'(seen_a), 32'(8'h80));
        chk("clr.seen_b", 32'(seen_b), 32'(8'h80));
        for (int i = 1; i < 10; i++) begin
            step();
            chk($sformatf("gap0.yv%0d", i), 32'(yv_b), 32'((i % 5) != 4));
            chk($sformatf("gap0.y%0d", i), 32'(y_b),
                32'(((i % 5) != 4) ? 8'h80 : 8'h00));
        end
        x_valid = 1'b0;

        // random traffic against the reference
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            x_valid = ($urandom_range(0, 2) != 0);
            x       = 3'($urandom);
            clr     = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
